// File: rtl/key_debounce_multi.sv
// N-channel debouncer for active-low keys: press/release/long-press events plus a level output.
// Each channel runs IDLE -> DEB_DN -> DOWN <-> DEB_UP -> IDLE after a shared post-reset blanking period.
module key_debounce_multi #(
  parameter int N_KEYS       = 4,
  parameter int DELAY_TIME   = 999_999,
  parameter int CNT_W        = 20,
  parameter int STARTUP_TIME = 4999,
  parameter int LONG_TICKS   = 100,
  parameter int LT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse
);

  localparam int BLANK_W = (STARTUP_TIME < 1) ? 1 : $clog2(STARTUP_TIME + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DEB_DN = 2'd1, DOWN = 2'd2, DEB_UP = 2'd3} state_t;

  logic [N_KEYS-1:0]  s1, s2, s3;
  logic [N_KEYS-1:0]  fall, rise;
  logic [BLANK_W-1:0] blank_cnt;
  logic               en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;
  assign en   = (blank_cnt == BLANK_W'(STARTUP_TIME));

  // Blanking counter stops at its terminal value; en stays high until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   blank_cnt <= '0;
    else if (!en) blank_cnt <= blank_cnt + 1'b1;
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [LT_W-1:0]  ltick, ltick_nxt;
    logic             cnt_done;
    logic             level_q, press_q, release_q, long_q;
    logic             press_nxt, release_nxt, long_nxt;

    assign cnt_done = (cnt == CNT_W'(DELAY_TIME));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        cnt       <= '0;
        ltick     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nxt;
        cnt       <= cnt_nxt;
        ltick     <= ltick_nxt;
        level_q   <= (state_nxt == DOWN) || (state_nxt == DEB_UP);
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (fall[g] && en) state_nxt = DEB_DN;
        DEB_DN:  if (s2[g])         state_nxt = IDLE;
                 else if (cnt_done) state_nxt = DOWN;
        DOWN:    if (rise[g])       state_nxt = DEB_UP;
        DEB_UP:  if (!s2[g])        state_nxt = DOWN;
                 else if (cnt_done) state_nxt = IDLE;
        default:                    state_nxt = IDLE;
      endcase
    end

    // A rise in DOWN takes priority over a window wrap landing on the same cycle.
    always_comb begin
      cnt_nxt     = '0;
      ltick_nxt   = ltick;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      case (state)
        DEB_DN: begin
          if (!s2[g] && !cnt_done) cnt_nxt = cnt + 1'b1;
          if (!s2[g] && cnt_done) begin
            press_nxt = 1'b1;
            ltick_nxt = '0;
          end
        end
        DOWN: begin
          if (!rise[g]) begin
            cnt_nxt = cnt_done ? '0 : cnt + 1'b1;
            if (cnt_done && (ltick != LT_W'(LONG_TICKS))) begin
              ltick_nxt = ltick + 1'b1;
              long_nxt  = (ltick == LT_W'(LONG_TICKS - 1));
            end
          end
        end
        DEB_UP: begin
          if (s2[g] && !cnt_done) cnt_nxt = cnt + 1'b1;
          if (s2[g] && cnt_done)  release_nxt = 1'b1;
        end
        default: cnt_nxt = '0;
      endcase
    end

    assign key_state[g]     = level_q;
    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign long_pulse[g]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random bouncing, checked every cycle
// against a timestamp-based reference model.
module tb_key_debounce_multi;
  localparam int N  = 4;
  localparam int D  = 9;
  localparam int ST = 19;
  localparam int LT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse;

  key_debounce_multi #(
    .N_KEYS(N), .DELAY_TIME(D), .CNT_W(4), .STARTUP_TIME(ST), .LONG_TICKS(LT), .LT_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(key_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  logic [N-1:0] hist[$];
  int ph[N], ts[N], ws[N], ticks[N];
  logic [N-1:0] e_state, e_press, e_rel, e_long;
  int press_n[N], press_at[N], rel_n[N], rel_at[N], long_n[N], long_at[N];

  // Pin sample taken at edge idx since reset release; before that the synchroniser reads idle high.
  function automatic logic [N-1:0] samp(int idx);
    if (idx <= 0) return '1;
    return hist[idx-1];
  endfunction

  task automatic model_reset();
    t = 0;
    hist.delete();
    for (int i = 0; i < N; i++) begin
      ph[i] = 0; ts[i] = 0; ws[i] = 0; ticks[i] = 0;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  // Phases: 0 idle, 1 confirming press, 2 held, 3 confirming release; times are edge numbers.
  task automatic model_edge(input logic [N-1:0] k);
    logic [N-1:0] a2, a3;
    logic         fell, rose, en;
    hist.push_back(k);
    a2 = samp(t - 2);
    a3 = samp(t - 3);
    en = (t - 1) >= ST;
    e_press = '0; e_rel = '0; e_long = '0;
    for (int i = 0; i < N; i++) begin
      fell = a3[i] && !a2[i];
      rose = !a3[i] && a2[i];
      case (ph[i])
        0: if (en && fell) begin ph[i] = 1; ts[i] = t; end
        1: if (a2[i]) ph[i] = 0;
           else if (t - ts[i] == D + 1) begin
             ph[i] = 2; ws[i] = t; ticks[i] = 0; e_press[i] = 1'b1;
           end
        2: if (rose) begin ph[i] = 3; ts[i] = t; end
           else if (((t - ws[i]) % (D + 1)) == 0 && ticks[i] < LT) begin
             ticks[i]++;
             if (ticks[i] == LT) e_long[i] = 1'b1;
           end
        default: if (!a2[i]) begin ph[i] = 2; ws[i] = t; end
           else if (t - ts[i] == D + 1) begin ph[i] = 0; e_rel[i] = 1'b1; end
      endcase
      e_state[i] = (ph[i] >= 2);
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    for (int i = 0; i < N; i++) begin
      press_n[i] = 0; rel_n[i] = 0; long_n[i] = 0;
      press_at[i] = -1; rel_at[i] = -1; long_at[i] = -1;
    end
  endtask

  // Called just after a posedge: drive pins, take the next edge, compare 1 time unit later.
  task automatic step(input logic [N-1:0] k);
    key_in = k;
    @(posedge clk);
    t++;
    model_edge(k);
    #1;
    chk("key_state", key_state, e_state);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("long_pulse", long_pulse, e_long);
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i])   begin press_n[i]++; if (press_at[i] < 0) press_at[i] = t; end
      if (release_pulse[i]) begin rel_n[i]++;   if (rel_at[i] < 0)   rel_at[i]   = t; end
      if (long_pulse[i])    begin long_n[i]++;  if (long_at[i] < 0)  long_at[i]  = t; end
    end
  endtask

  task automatic do_reset(input logic [N-1:0] k);
    #2;
    rst_n  = 1'b0;
    key_in = k;
    #1;
    chk("rst_key_state", key_state, '0);
    chk("rst_press", press_pulse, '0);
    chk("rst_release", release_pulse, '0);
    chk("rst_long", long_pulse, '0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [N-1:0] phase_a_key(int c);
    logic [N-1:0] k;
    k = '1;
    if (c >= 40 && c <= 139 && !(c >= 70 && c <= 73)) k[0] = 1'b0;
    if ((c >= 45 && c <= 49) || (c >= 53 && c <= 89))  k[1] = 1'b0;
    if (c >= 60 && c <= 149)                           k[2] = 1'b0;
    if (c <= 60 || (c >= 100 && c <= 129))             k[3] = 1'b0;
    return k;
  endfunction

  initial begin
    logic [N-1:0] cur;
    int           hold[N];
    rst_n  = 1'b0;
    key_in = 4'b0111;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(4'b0111);
    clear_events();

    // Clean press, bounce, long press, blanking with a pre-held key, release glitch.
    for (int c = 1; c <= 200; c++) step(phase_a_key(c));
    chk_int("press_at0", press_at[0], 52);
    chk_int("press_at1", press_at[1], 65);
    chk_int("press_at2", press_at[2], 72);
    chk_int("press_at3", press_at[3], 112);
    for (int i = 0; i < N; i++) begin
      chk_int("press_count", press_n[i], 1);
      chk_int("release_count", rel_n[i], 1);
    end
    chk_int("long_at0", long_at[0], 96);
    chk_int("long_at2", long_at[2], 102);
    chk_int("long_count0", long_n[0], 1);
    chk_int("long_count1", long_n[1], 0);
    chk_int("long_count2", long_n[2], 1);
    chk_int("long_count3", long_n[3], 0);
    chk_int("rel_at0", rel_at[0], 152);
    chk_int("rel_at1", rel_at[1], 102);
    chk_int("rel_at2", rel_at[2], 162);
    chk_int("rel_at3", rel_at[3], 142);

    // All keys together, then reset while they are held.
    clear_events();
    for (int c = 201; c <= 240; c++) step((c < 220) ? 4'hF : 4'h0);
    for (int i = 0; i < N; i++) chk_int("simul_press_at", press_at[i], 232);
    chk("held_before_reset", key_state, 4'hF);
    do_reset(4'h0);
    clear_events();
    for (int c = 1; c <= 110; c++) step((c >= 60 && c <= 79) ? 4'hF : 4'h0);
    for (int i = 0; i < N; i++) begin
      chk_int("repress_at", press_at[i], 92);
      chk_int("repress_count", press_n[i], 1);
      chk_int("repress_release_count", rel_n[i], 0);
    end

    // Random bouncing with a mix of short glitches and long holds.
    cur = '0;
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(5, 40);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          cur[i]  = ~cur[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 50);
        end else begin
          hold[i]--;
        end
      end
      step(cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
